// File: rtl/dm_bus_ctrl.sv
// Data-memory access controller: turns the CPU's zero-latency load/store into a
// req/ack transaction on a slow external bus, stalling the CPU until it completes.
module dm_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R,
  input  logic        W,
  input  logic [31:0] Addr,
  input  logic [31:0] W_data,
  output logic [31:0] R_data,
  output logic        stall,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    err_addr_q, err_addr_d;
  logic [DW-1:0]    maddr_q, maddr_d;
  logic [DW-1:0]    mwdata_q, mwdata_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic             we_q, we_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      err_q      <= err_d;
      req_q      <= req_d;
      we_q       <= we_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    err_d      = 1'b0;
    req_d      = req_q;
    we_d       = we_q;

    case (state_q)
      ST_IDLE: begin
        if (R || W) begin
          if ((R && W) || (Addr[1:0] != 2'b00)) begin
            state_d    = ST_DONE;
            err_d      = 1'b1;
            rdata_d    = ERR_DATA;
            err_addr_d = Addr;
          end else begin
            state_d  = ST_BUSY;
            maddr_d  = Addr;
            mwdata_d = W_data;
            we_d     = W;
            req_d    = 1'b1;
            cnt_d    = '0;
          end
        end
      end
      ST_BUSY: begin
        // An ack on the terminal-count cycle still completes cleanly
        if (mem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          err_addr_d = maddr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // DONE drops stall so the CPU commits on that edge; the held request is not re-issued
  assign stall = reset && (((state_q == ST_IDLE) && (R || W)) || (state_q == ST_BUSY));

  assign R_data    = rdata_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: per-cycle vector table plus hand-written
// timeout and terminal-count sequences.
module tb_dm_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        R, W;
  logic [31:0] Addr, W_data;
  logic [31:0] R_data;
  logic        stall, err;
  logic [31:0] err_addr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp;
  int n_fail;

  dm_bus_ctrl #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk      (clk),
    .reset    (reset),
    .R        (R),
    .W        (W),
    .Addr     (Addr),
    .W_data   (W_data),
    .R_data   (R_data),
    .stall    (stall),
    .err      (err),
    .err_addr (err_addr),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_erraddr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
  } vec_t;

  localparam int unsigned NV = 21;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check stall before the edge and registers after it
  task automatic apply(input int idx, input vec_t v);
    reset     = v.rst;
    R         = v.r;
    W         = v.w;
    Addr      = v.addr;
    W_data    = v.wdata;
    mem_rdata = v.rdata;
    mem_ack   = v.ack;
    #1;
    chk($sformatf("v%0d.stall", idx), 32'(stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.mem_req", idx),   32'(mem_req), 32'(v.e_req));
    chk($sformatf("v%0d.mem_we", idx),    32'(mem_we),  32'(v.e_we));
    chk($sformatf("v%0d.err", idx),       32'(err),     32'(v.e_err));
    chk($sformatf("v%0d.R_data", idx),    R_data,       v.e_rdata);
    chk($sformatf("v%0d.err_addr", idx),  err_addr,     v.e_erraddr);
    chk($sformatf("v%0d.mem_addr", idx),  mem_addr,     v.e_maddr);
    chk($sformatf("v%0d.mem_wdata", idx), mem_wdata,    v.e_mwdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  dropped;

    n_cmp  = 0;
    n_fail = 0;

    // rst r w addr wdata rdata ack | stall req we err R_data err_addr mem_addr mem_wdata
    tv[0]  = '{'0,'0,'0,32'h0,32'h0,32'h0,'0, '0,'0,'0,'0,32'h0,32'h0,32'h0,32'h0};
    tv[1]  = '{'0,'1,'0,32'h100,32'h0,32'h0,'0, '0,'0,'0,'0,32'h0,32'h0,32'h0,32'h0};
    // aligned load, ack in third BUSY cycle: 4 stall cycles
    tv[2]  = '{'1,'1,'0,32'h100,32'h0,32'h0,'0, '1,'1,'0,'0,32'h0,32'h0,32'h100,32'h0};
    tv[3]  = '{'1,'1,'0,32'h100,32'h0,32'h0,'0, '1,'1,'0,'0,32'h0,32'h0,32'h100,32'h0};
    tv[4]  = '{'1,'1,'0,32'h100,32'h0,32'h0,'0, '1,'1,'0,'0,32'h0,32'h0,32'h100,32'h0};
    tv[5]  = '{'1,'1,'0,32'h100,32'h0,32'h12345678,'1, '1,'0,'0,'0,32'h12345678,32'h0,32'h100,32'h0};
    tv[6]  = '{'1,'1,'0,32'h100,32'h0,32'h0,'0, '0,'0,'0,'0,32'h12345678,32'h0,32'h100,32'h0};
    tv[7]  = '{'1,'0,'0,32'h0,32'h0,32'h0,'0, '0,'0,'0,'0,32'h12345678,32'h0,32'h100,32'h0};
    // store with immediate ack: 2 stall cycles, R_data untouched
    tv[8]  = '{'1,'0,'1,32'h204,32'hA5A5A5A5,32'h0,'0, '1,'1,'1,'0,32'h12345678,32'h0,32'h204,32'hA5A5A5A5};
    tv[9]  = '{'1,'0,'1,32'h204,32'hA5A5A5A5,32'hFFFFFFFF,'1, '1,'0,'0,'0,32'h12345678,32'h0,32'h204,32'hA5A5A5A5};
    tv[10] = '{'1,'0,'1,32'h204,32'hA5A5A5A5,32'h0,'0, '0,'0,'0,'0,32'h12345678,32'h0,32'h204,32'hA5A5A5A5};
    // misaligned load: no bus cycle, 1 stall cycle
    tv[11] = '{'1,'1,'0,32'h102,32'h0,32'h0,'0, '1,'0,'0,'1,32'hDEADBEEF,32'h102,32'h204,32'hA5A5A5A5};
    tv[12] = '{'1,'1,'0,32'h102,32'h0,32'h0,'0, '0,'0,'0,'0,32'hDEADBEEF,32'h102,32'h204,32'hA5A5A5A5};
    tv[13] = '{'1,'0,'0,32'h0,32'h0,32'h0,'0, '0,'0,'0,'0,32'hDEADBEEF,32'h102,32'h204,32'hA5A5A5A5};
    // R and W together is an error
    tv[14] = '{'1,'1,'1,32'h400,32'h0,32'h0,'0, '1,'0,'0,'1,32'hDEADBEEF,32'h400,32'h204,32'hA5A5A5A5};
    tv[15] = '{'1,'1,'1,32'h400,32'h0,32'h0,'0, '0,'0,'0,'0,32'hDEADBEEF,32'h400,32'h204,32'hA5A5A5A5};
    // reset while BUSY, then a late ack in IDLE
    tv[16] = '{'1,'1,'0,32'h500,32'h0,32'h0,'0, '1,'1,'0,'0,32'hDEADBEEF,32'h400,32'h500,32'h0};
    tv[17] = '{'1,'1,'0,32'h500,32'h0,32'h0,'0, '1,'1,'0,'0,32'hDEADBEEF,32'h400,32'h500,32'h0};
    tv[18] = '{'0,'1,'0,32'h500,32'h0,32'h0,'0, '0,'0,'0,'0,32'h0,32'h0,32'h0,32'h0};
    tv[19] = '{'1,'0,'0,32'h0,32'h0,32'h77,'1, '0,'0,'0,'0,32'h0,32'h0,32'h0,32'h0};
    tv[20] = '{'1,'0,'0,32'h0,32'h0,32'h0,'0, '0,'0,'0,'0,32'h0,32'h0,32'h0,32'h0};

    reset = 1'b0; R = 1'b0; W = 1'b0; Addr = '0; W_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    for (int i = 0; i < int'(NV); i++) apply(i, tv[i]);

    // Timeout: load never acked, mem_req held 16 cycles
    R = 1'b1; Addr = 32'h300; mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("to.stall_idle", 32'(stall), 32'h1);
    @(posedge clk); #1;
    chk("to.req_rise", 32'(mem_req), 32'h1);
    chk("to.mem_addr", mem_addr, 32'h300);
    n = 0;
    dropped = 1'b0;
    while (!dropped && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!mem_req) dropped = 1'b1;
    end
    chk("to.req_cycles", 32'(n), 32'd16);
    chk("to.err", 32'(err), 32'h1);
    chk("to.R_data", R_data, 32'hDEADBEEF);
    chk("to.err_addr", err_addr, 32'h300);
    chk("to.stall_done", 32'(stall), 32'h0);
    R = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h99;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray.R_data", R_data, 32'hDEADBEEF);
    chk("stray.err", 32'(err), 32'h0);
    chk("stray.mem_req", 32'(mem_req), 32'h0);
    chk("stray.stall", 32'(stall), 32'h0);

    // Ack on the terminal-count cycle wins over the timeout
    R = 1'b1; Addr = 32'h304; mem_rdata = 32'h55;
    @(posedge clk); #1;
    chk("tc.req_rise", 32'(mem_req), 32'h1);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
    end
    chk("tc.req_before_last", 32'(mem_req), 32'h1);
    chk("tc.stall_before_last", 32'(stall), 32'h1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("tc.mem_req", 32'(mem_req), 32'h0);
    chk("tc.err", 32'(err), 32'h0);
    chk("tc.R_data", R_data, 32'h55);
    chk("tc.err_addr", err_addr, 32'h300);
    chk("tc.stall_done", 32'(stall), 32'h0);
    R = 1'b0;
    @(posedge clk); #1;
    chk("tc.idle_err", 32'(err), 32'h0);
    chk("tc.idle_stall", 32'(stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
